perf_counters_gen: RTL and testbench

- Parametrised successor to the fixed six-counter HPM block.
- Provides NumCounters programmable hardware performance counters (mhpmcounter3..), each selecting one of NumEvents event sources.
- Each source delivers a per-cycle increment count of 0..MaxInc, so multi-commit-port events add their true count per cycle instead of +1.
- Adds Sscofpmf-style mode filtering and overflow flags with an overflow interrupt request. Sits beside the CSR file, which forwards HPM CSR accesses to it.

---
 rtl/hpm_pkg.sv | 64 ++++++
 rtl/hpm_counter_slice.sv | 89 ++++++++
 rtl/perf_counters_gen.sv | 185 ++++++++++++++++++
 tb/tb_perf_counters_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_pkg.sv
// Shared definitions for the generic hardware performance counter block:
// mhpmevent field layout, HPM CSR base addresses and event source IDs.
package hpm_pkg;

   localparam int unsigned EVT_OF_BIT   = 63;
   localparam int unsigned EVT_MINH_BIT = 62;
   localparam int unsigned EVT_SINH_BIT = 61;
   localparam int unsigned EVT_UINH_BIT = 60;

   localparam logic [11:0] MHPMEVENT_BASE    = 12'h323;
   localparam logic [11:0] MHPMEVENTH_BASE   = 12'h723;
   localparam logic [11:0] MHPMCOUNTER_BASE  = 12'hB03;
   localparam logic [11:0] MHPMCOUNTERH_BASE = 12'hB83;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

   typedef enum logic [4:0] {
      EV_NONE         = 5'd0,
      EV_ICACHE_MISS  = 5'd1,
      EV_DCACHE_MISS  = 5'd2,
      EV_ITLB_MISS    = 5'd3,
      EV_DTLB_MISS    = 5'd4,
      EV_LOAD         = 5'd5,
      EV_STORE        = 5'd6,
      EV_EXCEPTION    = 5'd7,
      EV_EXC_RET      = 5'd8,
      EV_BRANCH       = 5'd9,
      EV_BRANCH_MISS  = 5'd10,
      EV_CALL         = 5'd11,
      EV_RET          = 5'd12,
      EV_MIS_PREDICT  = 5'd13,
      EV_SB_FULL      = 5'd14,
      EV_IF_EMPTY     = 5'd15,
      EV_INSTR_COMMIT = 5'd16,
      EV_INT_COMMIT   = 5'd17,
      EV_FP_COMMIT    = 5'd18,
      EV_AMO          = 5'd19,
      EV_CSR_ACCESS   = 5'd20,
      EV_FENCE        = 5'd21,
      EV_PIPE_BUBBLE  = 5'd22
   } hpm_event_e;

   typedef struct packed {
      logic ovf;
      logic minh;
      logic sinh;
      logic uinh;
   } evt_flags_t;

   // Privilege levels without a filter bit (reserved level 2) are never filtered.
   function automatic logic priv_inhibited(input evt_flags_t flags, input logic [1:0] priv);
      logic inh;
      case (priv)
         PRIV_M:  inh = flags.minh;
         PRIV_S:  inh = flags.sinh;
         PRIV_U:  inh = flags.uinh;
         default: inh = 1'b0;
      endcase
      return inh;
   endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One programmable performance counter: counter value, event selector,
// mode-filter bits and the sticky overflow flag.
module hpm_counter_slice
   import hpm_pkg::*;
#(
   parameter int unsigned CntWidth  = 64,
   parameter int unsigned IncWidth  = 2,
   parameter int unsigned SelW      = 5,
   parameter int unsigned NumEvents = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [1:0]          priv_lvl_i,
   input  logic                count_en_i,
   input  logic [IncWidth-1:0] inc_i,
   input  logic                cnt_we_i,
   input  logic [CntWidth-1:0] cnt_wdata_i,
   input  logic                evt_we_i,
   input  logic [63:0]         evt_wdata_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic [63:0]         evt_o,
   output logic [SelW-1:0]     sel_o,
   output logic                of_next_o
);

   localparam int unsigned SumW = CntWidth + 1;

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [SelW-1:0]     sel_q, sel_d;
   evt_flags_t          flags_q, flags_d;
   logic [SumW-1:0]     sum_s;
   logic                sel_valid_s;
   logic                incr_s;
   logic                unused_wdata_s;

   assign unused_wdata_s = ^evt_wdata_i;

   // Next-state: a counter write blocks the increment; an event write overrides OF.
   always_comb begin
      sel_valid_s = (sel_q != '0) && (32'(sel_q) < NumEvents);
      sum_s       = {1'b0, cnt_q} + SumW'(inc_i);
      incr_s      = count_en_i && !cnt_we_i && sel_valid_s && !priv_inhibited(flags_q, priv_lvl_i);
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      flags_d     = flags_q;
      if (cnt_we_i) begin
         cnt_d = cnt_wdata_i;
      end else if (incr_s) begin
         cnt_d       = sum_s[CntWidth-1:0];
         flags_d.ovf = flags_q.ovf | sum_s[CntWidth];
      end else begin
         cnt_d = cnt_q;
      end
      if (evt_we_i) begin
         flags_d = evt_flags_t'(evt_wdata_i[EVT_OF_BIT:EVT_UINH_BIT]);
         sel_d   = evt_wdata_i[SelW-1:0];
      end else begin
         sel_d = sel_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         sel_q   <= '0;
         flags_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         flags_q <= flags_d;
      end
   end

   // mhpmevent read view; unimplemented bits read zero.
   always_comb begin
      evt_o               = '0;
      evt_o[EVT_OF_BIT]   = flags_q.ovf;
      evt_o[EVT_MINH_BIT] = flags_q.minh;
      evt_o[EVT_SINH_BIT] = flags_q.sinh;
      evt_o[EVT_UINH_BIT] = flags_q.uinh;
      evt_o[SelW-1:0]     = sel_q;
   end

   assign cnt_o     = cnt_q;
   assign sel_o     = sel_q;
   assign of_next_o = flags_d.ovf;

endmodule

// File: rtl/perf_counters_gen.sv
// Parametrised HPM counter block: event pipeline and mux, HPM CSR decode and
// read mux, and the registered local counter-overflow interrupt request.
module perf_counters_gen
   import hpm_pkg::*;
#(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned NumCounters = 6,
   parameter int unsigned NumEvents   = 32,
   parameter int unsigned IncWidth    = 2,
   parameter int unsigned CntWidth    = 64,
   parameter int unsigned RegEvents   = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          debug_mode_i,
   input  logic [1:0]                    priv_lvl_i,
   input  logic [11:0]                   addr_i,
   input  logic                          we_i,
   input  logic [XLEN-1:0]               data_i,
   output logic [XLEN-1:0]               data_o,
   output logic                          access_ex_o,
   input  logic [NumEvents*IncWidth-1:0] events_i,
   input  logic [31:0]                   mcountinhibit_i,
   output logic                          lcofi_o
);

   localparam int unsigned SelW = (NumEvents > 1) ? $clog2(NumEvents) : 1;
   localparam int unsigned EvW  = NumEvents * IncWidth;

   logic [EvW-1:0]         ev_s;
   logic [63:0]            wdata_ext_s;
   logic [NumCounters-1:0] evt_lo_hit_s, evt_hi_hit_s, cnt_lo_hit_s, cnt_hi_hit_s;
   logic [NumCounters-1:0] of_next_s;
   logic                   any_hit_s;
   logic                   rd_hi_s;
   logic [63:0]            rd_word_s;
   logic [XLEN-1:0]        rdata_s;
   logic                   lcofi_q;
   logic                   unused_inhibit_s;
   logic [63:0]            slice_evt_s [NumCounters];
   logic [CntWidth-1:0]    slice_cnt_s [NumCounters];

   assign wdata_ext_s      = 64'(data_i);
   assign unused_inhibit_s = ^mcountinhibit_i;

   if (RegEvents != 0) begin : g_ev_reg
      logic [EvW-1:0] ev_q;
      // Event pipeline register; captures unconditionally every cycle.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ev_q <= '0;
         end else begin
            ev_q <= events_i;
         end
      end
      assign ev_s = ev_q;
   end else begin : g_ev_comb
      assign ev_s = events_i;
   end

   // CSR address decode; H-register addresses only exist for XLEN=32.
   always_comb begin
      evt_lo_hit_s = '0;
      evt_hi_hit_s = '0;
      cnt_lo_hit_s = '0;
      cnt_hi_hit_s = '0;
      for (int k = 0; k < NumCounters; k++) begin
         evt_lo_hit_s[k] = (addr_i == MHPMEVENT_BASE + 12'(k));
         cnt_lo_hit_s[k] = (addr_i == MHPMCOUNTER_BASE + 12'(k));
         evt_hi_hit_s[k] = (XLEN == 32) && (addr_i == MHPMEVENTH_BASE + 12'(k));
         cnt_hi_hit_s[k] = (XLEN == 32) && (addr_i == MHPMCOUNTERH_BASE + 12'(k));
      end
      any_hit_s = |{evt_lo_hit_s, evt_hi_hit_s, cnt_lo_hit_s, cnt_hi_hit_s};
   end

   for (genvar k = 0; k < NumCounters; k++) begin : g_slice
      logic [SelW-1:0]     sel_s;
      logic [IncWidth-1:0] inc_s;
      logic [63:0]         cnt_word_s, cnt_new_s, evt_new_s;
      logic                count_en_s;

      assign cnt_word_s = 64'(slice_cnt_s[k]);
      assign count_en_s = !debug_mode_i && !mcountinhibit_i[k+3];

      // Select this counter's increment from the (possibly delayed) event vector.
      always_comb begin
         inc_s = '0;
         for (int e = 0; e < NumEvents; e++) begin
            if (32'(sel_s) == e) begin
               inc_s = ev_s[e*IncWidth +: IncWidth];
            end else begin
               inc_s = inc_s;
            end
         end
      end

      // Word-merged write data: a 32-bit access replaces only the addressed half.
      always_comb begin
         if (cnt_hi_hit_s[k]) begin
            cnt_new_s = {wdata_ext_s[31:0], cnt_word_s[31:0]};
         end else if (XLEN == 64) begin
            cnt_new_s = wdata_ext_s;
         end else begin
            cnt_new_s = {cnt_word_s[63:32], wdata_ext_s[31:0]};
         end
         if (evt_hi_hit_s[k]) begin
            evt_new_s = {wdata_ext_s[31:0], slice_evt_s[k][31:0]};
         end else if (XLEN == 64) begin
            evt_new_s = wdata_ext_s;
         end else begin
            evt_new_s = {slice_evt_s[k][63:32], wdata_ext_s[31:0]};
         end
      end

      hpm_counter_slice #(
         .CntWidth  (CntWidth),
         .IncWidth  (IncWidth),
         .SelW      (SelW),
         .NumEvents (NumEvents)
      ) u_slice (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .priv_lvl_i  (priv_lvl_i),
         .count_en_i  (count_en_s),
         .inc_i       (inc_s),
         .cnt_we_i    (we_i && (cnt_lo_hit_s[k] || cnt_hi_hit_s[k])),
         .cnt_wdata_i (cnt_new_s[CntWidth-1:0]),
         .evt_we_i    (we_i && (evt_lo_hit_s[k] || evt_hi_hit_s[k])),
         .evt_wdata_i (evt_new_s),
         .cnt_o       (slice_cnt_s[k]),
         .evt_o       (slice_evt_s[k]),
         .sel_o       (sel_s),
         .of_next_o   (of_next_s[k])
      );
   end

   // CSR read mux.
   always_comb begin
      rd_word_s = '0;
      rd_hi_s   = 1'b0;
      for (int k = 0; k < NumCounters; k++) begin
         if (evt_lo_hit_s[k]) begin
            rd_word_s = slice_evt_s[k];
         end else if (evt_hi_hit_s[k]) begin
            rd_word_s = slice_evt_s[k];
            rd_hi_s   = 1'b1;
         end else if (cnt_lo_hit_s[k]) begin
            rd_word_s = 64'(slice_cnt_s[k]);
         end else if (cnt_hi_hit_s[k]) begin
            rd_word_s = 64'(slice_cnt_s[k]);
            rd_hi_s   = 1'b1;
         end else begin
            rd_word_s = rd_word_s;
         end
      end
      if (rd_hi_s) begin
         rdata_s = XLEN'(rd_word_s[63:32]);
      end else begin
         rdata_s = rd_word_s[XLEN-1:0];
      end
   end

   // Read outputs are forced quiet while reset is held.
   always_comb begin
      if (rst_ni) begin
         data_o      = rdata_s;
         access_ex_o = !any_hit_s;
      end else begin
         data_o      = '0;
         access_ex_o = 1'b0;
      end
   end

   // Interrupt request follows the OR of the next-cycle overflow flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lcofi_q <= 1'b0;
      end else begin
         lcofi_q <= |of_next_s;
      end
   end

   assign lcofi_o = lcofi_q;

endmodule

// File: tb/tb_perf_counters_gen.sv
// Directed bench for perf_counters_gen: a default XLEN=64 instance and an
// XLEN=32 / four-counter instance sharing clock, reset and event inputs.
module tb_perf_counters_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        debug_mode;
   logic [1:0]  priv;
   logic [63:0] events;
   logic [31:0] inhibit;
   logic [11:0] addr64, addr32;
   logic        we64, we32;
   logic [63:0] wdata64, rdata64;
   logic [31:0] wdata32, rdata32;
   logic        ex64, ex32, lcofi64, lcofi32;
   int          vectors = 0;
   int          miscompares = 0;

   always #50 clk = ~clk;

   perf_counters_gen u_dut64 (
      .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug_mode), .priv_lvl_i(priv),
      .addr_i(addr64), .we_i(we64), .data_i(wdata64), .data_o(rdata64),
      .access_ex_o(ex64), .events_i(events), .mcountinhibit_i(inhibit), .lcofi_o(lcofi64)
   );

   perf_counters_gen #(.XLEN(32), .NumCounters(4)) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug_mode), .priv_lvl_i(priv),
      .addr_i(addr32), .we_i(we32), .data_i(wdata32), .data_o(rdata32),
      .access_ex_o(ex32), .events_i(events), .mcountinhibit_i(inhibit), .lcofi_o(lcofi32)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ev(input int idx, input logic [1:0] v);
      events[idx*2 +: 2] = v;
   endtask

   task automatic wr64(input logic [11:0] a, input logic [63:0] d);
      addr64 = a; wdata64 = d; we64 = 1'b1;
      step(1);
      we64 = 1'b0;
   endtask

   task automatic rd64(input logic [11:0] a, output logic [63:0] d, output logic ex);
      addr64 = a; we64 = 1'b0;
      #1;
      d = rdata64; ex = ex64;
   endtask

   task automatic wr32(input logic [11:0] a, input logic [31:0] d);
      addr32 = a; wdata32 = d; we32 = 1'b1;
      step(1);
      we32 = 1'b0;
   endtask

   task automatic rd32(input logic [11:0] a, output logic [31:0] d, output logic ex);
      addr32 = a; we32 = 1'b0;
      #1;
      d = rdata32; ex = ex32;
   endtask

   task automatic test_reset;
      logic [63:0] d; logic ex;
      rd64(12'hFFF, d, ex);
      vectors++; if (ex !== 1'b0) begin miscompares++; $display("FAIL rst_hold_ex: got %0b expected 0", ex); end
      vectors++; if (lcofi64 !== 1'b0) begin miscompares++; $display("FAIL rst_hold_lcofi: got %0b expected 0", lcofi64); end
      @(posedge clk); #1; rst_n = 1'b1;
      step(1);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd0 || ex !== 1'b0) begin miscompares++; $display("FAIL rst_cnt0: got %0h/%0b expected 0/0", d, ex); end
      rd64(12'h328, d, ex);
      vectors++; if (d !== 64'd0 || ex !== 1'b0) begin miscompares++; $display("FAIL rst_evt5: got %0h/%0b expected 0/0", d, ex); end
      rd64(12'hFFF, d, ex);
      vectors++; if (d !== 64'd0 || ex !== 1'b1) begin miscompares++; $display("FAIL rst_unmapped: got %0h/%0b expected 0/1", d, ex); end
   endtask

   task automatic test_basic_count;
      logic [63:0] d; logic ex;
      wr64(12'h323, 64'd5);
      set_ev(5, 2'd2);
      step(10);
      set_ev(5, 2'd0);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd18) begin miscompares++; $display("FAIL basic_latency: got %0d expected 18", d); end
      step(1);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd20) begin miscompares++; $display("FAIL basic_total: got %0d expected 20", d); end
   endtask

   task automatic test_write_priority;
      logic [63:0] d; logic ex;
      set_ev(5, 2'd3);
      step(1);
      set_ev(5, 2'd0);
      wr64(12'hB03, 64'd7);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd7) begin miscompares++; $display("FAIL wr_prio: got %0d expected 7", d); end
      step(1);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd7) begin miscompares++; $display("FAIL wr_prio_hold: got %0d expected 7", d); end
   endtask

   task automatic test_wrap;
      logic [63:0] d; logic ex;
      wr64(12'hB04, 64'hFFFF_FFFF_FFFF_FFFE);
      wr64(12'h324, 64'd1);
      set_ev(1, 2'd3);
      step(1);
      set_ev(1, 2'd0);
      vectors++; if (lcofi64 !== 1'b0) begin miscompares++; $display("FAIL wrap_pre_lcofi: got %0b expected 0", lcofi64); end
      step(1);
      rd64(12'hB04, d, ex);
      vectors++; if (d !== 64'd1) begin miscompares++; $display("FAIL wrap_cnt: got %0h expected 1", d); end
      rd64(12'h324, d, ex);
      vectors++; if (d !== 64'h8000_0000_0000_0001) begin miscompares++; $display("FAIL wrap_of: got %0h expected 8000000000000001", d); end
      vectors++; if (lcofi64 !== 1'b1) begin miscompares++; $display("FAIL wrap_lcofi: got %0b expected 1", lcofi64); end
      step(1);
      vectors++; if (lcofi64 !== 1'b1) begin miscompares++; $display("FAIL wrap_sticky: got %0b expected 1", lcofi64); end
      wr64(12'h324, 64'd1);
      vectors++; if (lcofi64 !== 1'b0) begin miscompares++; $display("FAIL of_clear_lcofi: got %0b expected 0", lcofi64); end
      rd64(12'h324, d, ex);
      vectors++; if (d !== 64'd1) begin miscompares++; $display("FAIL of_clear_evt: got %0h expected 1", d); end
   endtask

   task automatic test_mode_filter;
      logic [63:0] d; logic ex;
      wr64(12'h325, 64'h1000_0000_0000_0001);
      priv = 2'd0;
      set_ev(1, 2'd1);
      step(4);
      rd64(12'hB05, d, ex);
      vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL filt_umode: got %0d expected 0", d); end
      priv = 2'd3;
      step(4);
      rd64(12'hB05, d, ex);
      vectors++; if (d !== 64'd4) begin miscompares++; $display("FAIL filt_mmode: got %0d expected 4", d); end
      priv = 2'd1;
      step(2);
      set_ev(1, 2'd0);
      priv = 2'd0;
      step(2);
      priv = 2'd3;
      rd64(12'hB05, d, ex);
      vectors++; if (d !== 64'd6) begin miscompares++; $display("FAIL filt_smode: got %0d expected 6", d); end
   endtask

   task automatic test_inhibit_debug;
      logic [63:0] d; logic ex;
      inhibit[3] = 1'b1;
      set_ev(5, 2'd1);
      step(5);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd7) begin miscompares++; $display("FAIL inhibit: got %0d expected 7", d); end
      inhibit[3] = 1'b0;
      debug_mode = 1'b1;
      step(5);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd7) begin miscompares++; $display("FAIL debug: got %0d expected 7", d); end
      debug_mode = 1'b0;
      step(3);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd10) begin miscompares++; $display("FAIL resume: got %0d expected 10", d); end
      set_ev(5, 2'd0);
      step(2);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd11) begin miscompares++; $display("FAIL resume_drain: got %0d expected 11", d); end
   endtask

   task automatic test_csr_map64;
      logic [63:0] d; logic ex;
      rd64(12'hB83, d, ex);
      vectors++; if (d !== 64'd0 || ex !== 1'b1) begin miscompares++; $display("FAIL h_addr64: got %0h/%0b expected 0/1", d, ex); end
      wr64(12'h723, 64'hFFFF_FFFF_FFFF_FFFF);
      rd64(12'h323, d, ex);
      vectors++; if (d !== 64'd5) begin miscompares++; $display("FAIL h_write64: got %0h expected 5", d); end
      rd64(12'h329, d, ex);
      vectors++; if (ex !== 1'b1) begin miscompares++; $display("FAIL evt6_unmapped: got %0b expected 1", ex); end
   endtask

   task automatic test_xlen32;
      logic [31:0] d; logic ex;
      wr32(12'hB83, 32'h1);
      wr32(12'hB03, 32'hFFFF_FFFF);
      rd32(12'hB03, d, ex);
      vectors++; if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL x32_lo: got %0h expected ffffffff", d); end
      rd32(12'hB83, d, ex);
      vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL x32_hi: got %0h expected 1", d); end
      wr32(12'h723, 32'hF000_0000);
      rd32(12'h723, d, ex);
      vectors++; if (d !== 32'hF000_0000) begin miscompares++; $display("FAIL x32_evth: got %0h expected f0000000", d); end
      vectors++; if (lcofi32 !== 1'b1) begin miscompares++; $display("FAIL x32_lcofi: got %0b expected 1", lcofi32); end
      wr32(12'h323, 32'hFFFF_FFFF);
      rd32(12'h323, d, ex);
      vectors++; if (d !== 32'h1F) begin miscompares++; $display("FAIL x32_evtl: got %0h expected 1f", d); end
      rd32(12'h723, d, ex);
      vectors++; if (d !== 32'hF000_0000) begin miscompares++; $display("FAIL x32_evth_keep: got %0h expected f0000000", d); end
      rd32(12'hB07, d, ex);
      vectors++; if (d !== 32'h0 || ex !== 1'b1) begin miscompares++; $display("FAIL x32_b07: got %0h/%0b expected 0/1", d, ex); end
      rd32(12'hB86, d, ex);
      vectors++; if (ex !== 1'b0) begin miscompares++; $display("FAIL x32_b86: got %0b expected 0", ex); end
   endtask

   task automatic test_reset_mid;
      logic [63:0] d; logic ex;
      wr64(12'h325, 64'h9000_0000_0000_0001);
      vectors++; if (lcofi64 !== 1'b1) begin miscompares++; $display("FAIL mid_pre_lcofi: got %0b expected 1", lcofi64); end
      #20;
      rst_n = 1'b0;
      #1;
      vectors++; if (lcofi64 !== 1'b0) begin miscompares++; $display("FAIL mid_lcofi: got %0b expected 0", lcofi64); end
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL mid_data: got %0h expected 0", d); end
      @(posedge clk); #1; rst_n = 1'b1;
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL post_cnt0: got %0h expected 0", d); end
      rd64(12'h325, d, ex);
      vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL post_evt2: got %0h expected 0", d); end
      wr64(12'h323, 64'd5);
      set_ev(5, 2'd1);
      step(1);
      set_ev(5, 2'd0);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL post_latency: got %0d expected 0", d); end
      step(1);
      rd64(12'hB03, d, ex);
      vectors++; if (d !== 64'd1) begin miscompares++; $display("FAIL post_count: got %0d expected 1", d); end
   endtask

   initial begin
      rst_n = 1'b1; debug_mode = 1'b0; priv = 2'd3; events = '0; inhibit = '0;
      addr64 = 12'h0; addr32 = 12'h0; we64 = 1'b0; we32 = 1'b0; wdata64 = '0; wdata32 = '0;
      #1 rst_n = 1'b0;
      #20;
      test_reset();
      test_basic_count();
      test_write_priority();
      test_wrap();
      test_mode_filter();
      test_inhibit_debug();
      test_csr_map64();
      test_xlen32();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
